// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder sums behind valid/ready handshakes.
// Optional SUM_ACC_SAT_EN: saturate instead of wrap on accumulator overflow.
module sum_accumulator #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [ACC_W-1:0] acc_n;
  logic             ovf_n;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             accept;

  assign sum_ext = {1'b0, acc_out}
                 + {{(ACC_W+1-IN_W){1'b0}}, in_sum};
  assign carry   = sum_ext[ACC_W];
  assign accept  = (state == ACCUM) & in_valid & in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc_out;
    ovf_n   = ovf;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_n = '0;
          ovf_n = 1'b0;
          cnt_n = len;
          if (len == '0) state_n = DONE;
          else           state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_n = cnt - CNT_W'(1);
          ovf_n = ovf | carry;
`ifdef SUM_ACC_SAT_EN
          // once saturated, the total is pinned for the rest of the run
          if (ovf || carry) acc_n = '1;
          else              acc_n = sum_ext[ACC_W-1:0];
`else
          acc_n = sum_ext[ACC_W-1:0];
`endif
          if (cnt == CNT_W'(1)) state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // handshake outputs are registered off the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc_out   <= acc_n;
      ovf       <= ovf_n;
      in_ready  <= (state_n == ACCUM);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed, table-driven bench for sum_accumulator.
// Overflow expectations follow SUM_ACC_SAT_EN when defined.
module tb_sum_accumulator;

  typedef struct {
    int          len;
    logic [16:0] s0;
    logic [16:0] s1;
    logic [16:0] s2;
    logic [16:0] s3;
    logic [16:0] fill;
    logic [23:0] acc;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] acc_out;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;
  vec_t vecs[8];

  sum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int l, logic [16:0] a, logic [16:0] b,
                              logic [16:0] c, logic [16:0] d,
                              logic [16:0] f, logic [23:0] e,
                              logic o);
    vec_t v;
    v.len = l; v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d;
    v.fill = f; v.acc = e; v.ovf = o;
    return v;
  endfunction

  function automatic logic [16:0] val(vec_t v, int i);
    case (i)
      0: return v.s0;
      1: return v.s1;
      2: return v.s2;
      3: return v.s3;
      default: return v.fill;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic feed(int k);
    int i = 0;
    int guard = 0;
    while (i < vecs[k].len && guard < 2000) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_sum = val(vecs[k], i);
        i++;
      end else begin
        in_valid = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (guard >= 2000) chk("feed_timeout", 32'(i), 32'(vecs[k].len));
  endtask

  task automatic run_vec(int k, int hold);
    @(negedge clk);
    start = 1'b1;
    len = 8'(vecs[k].len);
    @(negedge clk);
    start = 1'b0;
    len = '0;
    feed(k);
    chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_acc", k), 32'(acc_out), 32'(vecs[k].acc));
    chk($sformatf("v%0d_ovf", k), 32'(ovf), 32'(vecs[k].ovf));
    chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'd0);
    chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len = 8'd7;
      @(negedge clk);
      chk("bp_acc_stable", 32'(acc_out), 32'(vecs[k].acc));
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    start = 1'b0;
    len = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_idle_valid", k), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'd0);
    chk($sformatf("v%0d_idle_acc", k), 32'(acc_out), 32'(vecs[k].acc));
  endtask

  initial begin
    vecs[0] = mk(3, 17'h131B5, 17'h131B5, 17'h00001, 0, 0,
                 24'h02636B, 1'b0);
    vecs[1] = mk(1, 17'h5, 0, 0, 0, 0, 24'h000005, 1'b0);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 24'h000000, 1'b0);
`ifdef SUM_ACC_SAT_EN
    vecs[3] = mk(129, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                 17'h1FFFF, 24'hFFFFFF, 1'b1);
`else
    vecs[3] = mk(129, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                 17'h1FFFF, 24'h01FF7F, 1'b1);
`endif
    vecs[4] = mk(2, 17'h1FFFF, 17'h1FFFF, 0, 0, 0, 24'h03FFFE, 1'b0);
    vecs[5] = mk(4, 17'h1, 17'h2, 17'h3, 17'h4, 0, 24'h00000A, 1'b0);
    vecs[6] = mk(255, 17'h10000, 17'h10000, 17'h10000, 17'h10000,
                 17'h10000, 24'hFF0000, 1'b0);
    vecs[7] = mk(128, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                 17'h1FFFF, 24'hFFFF80, 1'b0);

    rst_n = 1'b0; start = 1'b0; len = '0;
    in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    run_vec(0, 5);
    for (int k = 1; k < 8; k++) run_vec(k, 0);

    // in_valid while idle must not accumulate
    in_valid = 1'b1;
    in_sum = 17'h00123;
    repeat (3) @(negedge clk);
    chk("idle_acc", 32'(acc_out), 32'(vecs[7].acc));
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // gapped valid: 1,0,1,0,1 -> 1+2+4
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_sum = 17'd1; @(negedge clk);
    in_valid = 1'b0; in_sum = 17'd100; @(negedge clk);
    in_valid = 1'b1; in_sum = 17'd2; @(negedge clk);
    in_valid = 1'b0; in_sum = 17'd7; @(negedge clk);
    chk("gap_in_ready", 32'(in_ready), 32'd1);
    chk("gap_not_done", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_sum = 17'd4; @(negedge clk);
    in_valid = 1'b0;
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_acc", 32'(acc_out), 32'd7);
    chk("gap_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    chk("gap_idle", 32'(busy), 32'd0);

    // reset in the middle of a run
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_sum = 17'h10; @(negedge clk);
    in_valid = 1'b0;
    chk("mid_acc_partial", 32'(acc_out), 32'h10);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_acc", 32'(acc_out), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    run_vec(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
